// File: rtl/plic_claim_agent.sv
// ============================================================================
// Module   : plic_claim_agent
// Purpose  : Claims PLIC interrupts over MMIO, hands IDs to the core,
//            writes completion and programs the context threshold.
// Revision : 1.0
// ============================================================================
`default_nettype none

module plic_claim_agent #(
    parameter int                    ADDR_WIDTH     = 64,
    parameter int                    DATA_WIDTH     = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR      = 'h0C00_0000,
    parameter int                    CONTEXT_ID     = 0,
    parameter int                    ID_WIDTH       = 5,
    parameter int                    TIMEOUT_CYCLES = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ext_irq,
    output logic [ADDR_WIDTH-1:0] mmio_addr,
    output logic [DATA_WIDTH-1:0] mmio_write_data,
    output logic                  mmio_read,
    output logic                  mmio_write,
    output logic [7:0]            mmio_byte_en,
    input  logic [DATA_WIDTH-1:0] mmio_read_data,
    input  logic                  mmio_ready,
    input  logic                  mmio_error,
    input  logic                  thr_wr,
    input  logic [2:0]            thr_val,
    output logic                  irq_valid,
    output logic [ID_WIDTH-1:0]   irq_id,
    input  logic                  irq_ready,
    input  logic                  irq_done,
    output logic                  busy,
    output logic                  err,
    output logic [15:0]           spurious_cnt
);

    localparam logic [ADDR_WIDTH-1:0] CTX_ADDR =
        BASE_ADDR + ADDR_WIDTH'(32'h0020_0000) + ADDR_WIDTH'(CONTEXT_ID * 32'h20);
    localparam logic [ADDR_WIDTH-1:0] THR_ADDR = CTX_ADDR;
    localparam logic [ADDR_WIDTH-1:0] CLM_ADDR = CTX_ADDR + ADDR_WIDTH'(4);

    localparam int             TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0]  TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_THRESH   = 3'd1;
    localparam logic [2:0] ST_CLAIM    = 3'd2;
    localparam logic [2:0] ST_DISPATCH = 3'd3;
    localparam logic [2:0] ST_SERVICE  = 3'd4;
    localparam logic [2:0] ST_COMPLETE = 3'd5;

    logic [2:0]            state_q,    state_d;
    logic [2:0]            thr_pend_q, thr_pend_d;
    logic                  thr_vld_q,  thr_vld_d;
    logic [ID_WIDTH-1:0]   id_q,       id_d;
    logic [TW-1:0]         tmo_q,      tmo_d;
    logic                  err_q,      err_d;
    logic [15:0]           spur_q,     spur_d;
    logic [ADDR_WIDTH-1:0] addr_q,     addr_d;
    logic [DATA_WIDTH-1:0] wdata_q,    wdata_d;
    logic                  rd_q,       rd_d;
    logic                  wr_q,       wr_d;
    logic [7:0]            be_q,       be_d;

    logic                  w_hold;
    logic                  w_thr_pend;
    logic [2:0]            w_thr_val;
    logic [ID_WIDTH-1:0]   w_rid;
    logic                  w_unused;

    assign w_unused   = ^mmio_read_data[DATA_WIDTH-1:ID_WIDTH];
    assign w_rid      = mmio_read_data[ID_WIDTH-1:0];
    // A pulse arriving in the same IDLE cycle as ext_irq still wins priority.
    assign w_thr_pend = thr_wr | thr_vld_q;
    assign w_thr_val  = thr_wr ? thr_val : thr_pend_q;

    always_comb begin
        state_d    = state_q;
        thr_pend_d = thr_pend_q;
        thr_vld_d  = thr_vld_q;
        id_d       = id_q;
        err_d      = err_q;
        spur_d     = spur_q;
        w_hold     = 1'b0;

        if (thr_wr) begin
            thr_pend_d = thr_val;
            thr_vld_d  = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (w_thr_pend) begin
                    state_d = ST_THRESH;
                end else if (ext_irq) begin
                    state_d = ST_CLAIM;
                end
            end
            ST_THRESH, ST_CLAIM, ST_COMPLETE: begin
                if (mmio_ready) begin
                    state_d = ST_IDLE;
                    if (mmio_error) begin
                        err_d = 1'b1;
                    end else if (state_q == ST_THRESH) begin
                        if (!thr_wr) begin
                            thr_vld_d = 1'b0;
                        end
                    end else if (state_q == ST_CLAIM) begin
                        if (w_rid == '0) begin
                            spur_d = (spur_q == 16'hFFFF) ? spur_q : spur_q + 16'd1;
                        end else begin
                            id_d    = w_rid;
                            state_d = ST_DISPATCH;
                        end
                    end
                end else if (tmo_q == TMO_LAST) begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    w_hold = 1'b1;
                end
            end
            ST_DISPATCH: begin
                if (irq_ready) begin
                    state_d = ST_SERVICE;
                end
            end
            ST_SERVICE: begin
                if (irq_done) begin
                    state_d = ST_COMPLETE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Holding in the same request state is the only way to keep counting.
        tmo_d = w_hold ? tmo_q + TW'(1) : '0;
    end

    // Request outputs are registered from the next state so they rise on entry.
    always_comb begin
        rd_d    = 1'b0;
        wr_d    = 1'b0;
        be_d    = 8'h00;
        addr_d  = '0;
        wdata_d = '0;
        case (state_d)
            ST_THRESH: begin
                wr_d    = 1'b1;
                be_d    = 8'h0F;
                addr_d  = THR_ADDR;
                wdata_d = (state_q == ST_THRESH) ? wdata_q : DATA_WIDTH'(w_thr_val);
            end
            ST_CLAIM: begin
                rd_d   = 1'b1;
                be_d   = 8'h0F;
                addr_d = CLM_ADDR;
            end
            ST_COMPLETE: begin
                wr_d    = 1'b1;
                be_d    = 8'h0F;
                addr_d  = CLM_ADDR;
                wdata_d = DATA_WIDTH'(id_q);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            thr_pend_q <= '0;
            thr_vld_q  <= 1'b0;
            id_q       <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            spur_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            be_q       <= 8'h00;
        end else begin
            state_q    <= state_d;
            thr_pend_q <= thr_pend_d;
            thr_vld_q  <= thr_vld_d;
            id_q       <= id_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            spur_q     <= spur_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            be_q       <= be_d;
        end
    end

    assign mmio_addr       = addr_q;
    assign mmio_write_data = wdata_q;
    assign mmio_read       = rd_q;
    assign mmio_write      = wr_q;
    assign mmio_byte_en    = be_q;
    assign irq_valid       = (state_q == ST_DISPATCH);
    assign irq_id          = id_q;
    assign busy            = (state_q != ST_IDLE);
    assign err             = err_q;
    assign spurious_cnt    = spur_q;

endmodule

`default_nettype wire

// File: tb/tb_plic_claim_agent.sv
// ============================================================================
// Module   : tb_plic_claim_agent
// Purpose  : Scoreboard bench for plic_claim_agent with an MMIO responder model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_plic_claim_agent;

    localparam logic [63:0] THR_A = 64'h0C20_0020;
    localparam logic [63:0] CLM_A = 64'h0C20_0024;

    typedef struct {
        logic        wr;
        logic [63:0] addr;
        logic [63:0] data;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ext_irq = 1'b0;
    logic [63:0] mmio_addr;
    logic [63:0] mmio_write_data;
    logic        mmio_read;
    logic        mmio_write;
    logic [7:0]  mmio_byte_en;
    logic [63:0] mmio_read_data = '0;
    logic        mmio_ready = 1'b0;
    logic        mmio_error = 1'b0;
    logic        thr_wr = 1'b0;
    logic [2:0]  thr_val = '0;
    logic        irq_valid;
    logic [4:0]  irq_id;
    logic        irq_ready = 1'b1;
    logic        irq_done = 1'b0;
    logic        busy;
    logic        err;
    logic [15:0] spurious_cnt;

    txn_t        exp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;
    int          rsp_wait = 0;
    logic [63:0] rsp_rdata = '0;
    logic        rsp_err_wr = 1'b0;
    int          rsp_cnt = 0;
    logic        rsp_seen = 1'b0;
    logic        auto_done = 1'b0;
    logic        man_done = 1'b0;
    logic        irq_seen = 1'b0;

    plic_claim_agent #(
        .ADDR_WIDTH    (64),
        .DATA_WIDTH    (64),
        .BASE_ADDR     (64'h0C00_0000),
        .CONTEXT_ID    (1),
        .ID_WIDTH      (5),
        .TIMEOUT_CYCLES(16)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .ext_irq        (ext_irq),
        .mmio_addr      (mmio_addr),
        .mmio_write_data(mmio_write_data),
        .mmio_read      (mmio_read),
        .mmio_write     (mmio_write),
        .mmio_byte_en   (mmio_byte_en),
        .mmio_read_data (mmio_read_data),
        .mmio_ready     (mmio_ready),
        .mmio_error     (mmio_error),
        .thr_wr         (thr_wr),
        .thr_val        (thr_val),
        .irq_valid      (irq_valid),
        .irq_id         (irq_id),
        .irq_ready      (irq_ready),
        .irq_done       (irq_done),
        .busy           (busy),
        .err            (err),
        .spurious_cnt   (spurious_cnt)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push_txn(input logic wr, input logic [63:0] addr, input logic [63:0] data);
        txn_t t;
        t.wr = wr;
        t.addr = addr;
        t.data = data;
        exp_q.push_back(t);
    endtask

    // Responder: checks each new request against the scoreboard, answers after rsp_wait cycles.
    always @(negedge clk) begin
        if (rst || !(mmio_read || mmio_write)) begin
            mmio_ready = 1'b0;
            mmio_error = 1'b0;
            rsp_cnt    = 0;
            rsp_seen   = 1'b0;
        end else begin
            if (!rsp_seen) begin
                txn_t t;
                rsp_seen = 1'b1;
                check_eq("strobe_excl", {63'd0, mmio_read & mmio_write}, 64'd0);
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_txn", {63'd0, mmio_write}, 64'd2);
                end else begin
                    t = exp_q.pop_front();
                    check_eq("txn_kind", {63'd0, mmio_write}, {63'd0, t.wr});
                    check_eq("txn_addr", mmio_addr, t.addr);
                    check_eq("txn_be", {56'd0, mmio_byte_en}, 64'h0F);
                    if (t.wr) check_eq("txn_data", mmio_write_data, t.data);
                end
            end
            if (rsp_wait >= 0 && rsp_cnt >= rsp_wait) begin
                mmio_ready     = 1'b1;
                mmio_read_data = rsp_rdata;
                mmio_error     = rsp_err_wr & mmio_write;
            end else begin
                mmio_ready = 1'b0;
                rsp_cnt++;
            end
        end
    end

    // Core model: in auto mode, finish as soon as the agent sits in SERVICE.
    always @(negedge clk) begin
        irq_done = auto_done ? (busy & ~irq_valid & ~mmio_read & ~mmio_write) : man_done;
        if (irq_valid) irq_seen = 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!irq_valid && n < 60) begin
            step();
            n++;
        end
        check_eq(tag, {63'd0, irq_valid}, 64'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 200) begin
            step();
            n++;
        end
        check_eq(tag, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc;

        repeat (3) step();
        check_eq("rst_busy", {63'd0, busy}, 64'd0);
        check_eq("rst_err", {63'd0, err}, 64'd0);
        check_eq("rst_spur", {48'd0, spurious_cnt}, 64'd0);
        check_eq("rst_strobes", {62'd0, mmio_read, mmio_write}, 64'd0);
        check_eq("rst_addr", mmio_addr, 64'd0);
        check_eq("rst_be", {56'd0, mmio_byte_en}, 64'd0);
        check_eq("rst_irq", {58'd0, irq_valid, irq_id}, 64'd0);
        rst = 1'b0;
        step();

        // Minimum latency: zero-wait responder, immediate core.
        rsp_wait = 0;
        rsp_rdata = 64'h3;
        auto_done = 1'b1;
        push_txn(1'b0, CLM_A, 64'd0);
        push_txn(1'b1, CLM_A, 64'h3);
        ext_irq = 1'b1;
        step();
        ext_irq = 1'b0;
        check_eq("lat_read_next", {63'd0, mmio_read}, 64'd1);
        cyc = 1;
        while (busy && cyc < 20) begin
            step();
            cyc++;
        end
        check_eq("lat_cycles", cyc, 5);

        // Context 1 claim of ID 7, core finishes 3 cycles into service.
        auto_done = 1'b0;
        rsp_rdata = 64'h7;
        push_txn(1'b0, CLM_A, 64'd0);
        push_txn(1'b1, CLM_A, 64'h7);
        ext_irq = 1'b1;
        wait_valid("id7_valid");
        ext_irq = 1'b0;
        check_eq("id7_id", {59'd0, irq_id}, 64'h7);
        step();
        check_eq("id7_service", {62'd0, busy, irq_valid}, 64'd2);
        repeat (3) step();
        man_done = 1'b1;
        step();
        man_done = 1'b0;
        wait_idle("id7_idle");
        check_eq("id7_q_empty", exp_q.size(), 0);

        // Three spurious claims.
        rsp_rdata = 64'h0;
        irq_seen = 1'b0;
        repeat (3) push_txn(1'b0, CLM_A, 64'd0);
        ext_irq = 1'b1;
        cyc = 0;
        while (spurious_cnt != 16'd3 && cyc < 60) begin
            step();
            cyc++;
        end
        ext_irq = 1'b0;
        check_eq("spur_cnt", {48'd0, spurious_cnt}, 64'd3);
        wait_idle("spur_idle");
        repeat (3) step();
        check_eq("spur_no_valid", {63'd0, irq_seen}, 64'd0);
        check_eq("spur_q_empty", exp_q.size(), 0);

        // Threshold and interrupt together: threshold write first, with wait states.
        rsp_wait = 2;
        rsp_rdata = 64'h9;
        auto_done = 1'b1;
        push_txn(1'b1, THR_A, 64'h5);
        push_txn(1'b0, CLM_A, 64'd0);
        push_txn(1'b1, CLM_A, 64'h9);
        thr_wr = 1'b1;
        thr_val = 3'd5;
        ext_irq = 1'b1;
        step();
        thr_wr = 1'b0;
        wait_valid("thr_valid");
        ext_irq = 1'b0;
        check_eq("thr_id", {59'd0, irq_id}, 64'h9);
        wait_idle("thr_idle");
        check_eq("thr_q_empty", exp_q.size(), 0);
        check_eq("thr_err", {63'd0, err}, 64'd0);

        // Claim never answered: times out after 16 held cycles.
        rsp_wait = -1;
        push_txn(1'b0, CLM_A, 64'd0);
        ext_irq = 1'b1;
        step();
        ext_irq = 1'b0;
        cyc = 0;
        while (mmio_read && cyc < 100) begin
            cyc++;
            step();
        end
        check_eq("tmo_cycles", cyc, 16);
        check_eq("tmo_err", {63'd0, err}, 64'd1);
        check_eq("tmo_busy", {63'd0, busy}, 64'd0);
        step();
        check_eq("tmo_err_sticky", {63'd0, err}, 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("tmo_rst_err", {63'd0, err}, 64'd0);

        // Reset while servicing ID 0x1F abandons the completion and pending threshold.
        rsp_wait = 0;
        rsp_rdata = 64'h1F;
        auto_done = 1'b0;
        push_txn(1'b0, CLM_A, 64'd0);
        ext_irq = 1'b1;
        wait_valid("rs_valid");
        ext_irq = 1'b0;
        check_eq("rs_id", {59'd0, irq_id}, 64'h1F);
        step();
        thr_wr = 1'b1;
        thr_val = 3'd3;
        step();
        thr_wr = 1'b0;
        check_eq("rs_in_service", {62'd0, busy, irq_valid}, 64'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_eq("rs_busy", {63'd0, busy}, 64'd0);
        check_eq("rs_irq", {58'd0, irq_valid, irq_id}, 64'd0);
        check_eq("rs_strobes", {62'd0, mmio_read, mmio_write}, 64'd0);
        check_eq("rs_addr_data", mmio_addr | mmio_write_data, 64'd0);
        man_done = 1'b1;
        step();
        man_done = 1'b0;
        repeat (10) step();
        check_eq("rs_quiet_busy", {63'd0, busy}, 64'd0);
        check_eq("rs_q_empty", exp_q.size(), 0);

        // Error on completion write, then a normal claim keeps err set.
        rsp_rdata = 64'hA;
        rsp_err_wr = 1'b1;
        auto_done = 1'b1;
        push_txn(1'b0, CLM_A, 64'd0);
        push_txn(1'b1, CLM_A, 64'hA);
        ext_irq = 1'b1;
        wait_valid("ce_valid");
        ext_irq = 1'b0;
        wait_idle("ce_idle");
        check_eq("ce_err", {63'd0, err}, 64'd1);
        rsp_err_wr = 1'b0;
        rsp_rdata = 64'h2;
        push_txn(1'b0, CLM_A, 64'd0);
        push_txn(1'b1, CLM_A, 64'h2);
        ext_irq = 1'b1;
        wait_valid("ce2_valid");
        ext_irq = 1'b0;
        check_eq("ce2_id", {59'd0, irq_id}, 64'h2);
        wait_idle("ce2_idle");
        check_eq("ce2_err", {63'd0, err}, 64'd1);
        check_eq("ce2_q_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/plic_claim_agent.md
PLIC_CLAIM_AGENT -- requirements
Module: plic_claim_agent

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH 64, MMIO address width; DATA_WIDTH 64, MMIO data width; BASE_ADDR 64'h0C000000, PLIC base; CONTEXT_ID 0, PLIC context serviced; ID_WIDTH 5, source ID width; TIMEOUT_CYCLES 256, MMIO ready timeout.
REQ-002 SHALL use a single clock and a synchronous, active-high reset.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 ext_irq  in  1  external interrupt line from PLIC for CONTEXT_ID.
REQ-006 mmio_addr  out  ADDR_WIDTH  request address.
REQ-007 mmio_write_data  out  DATA_WIDTH  write data.
REQ-008 mmio_read / mmio_write  out  1 each  request strobes, mutually exclusive.
REQ-009 mmio_byte_en  out  8  byte enables.
REQ-010 mmio_read_data  in  DATA_WIDTH; mmio_ready  in  1; mmio_error  in  1  responder return.
REQ-011 thr_wr  in  1  one-cycle request to program threshold; thr_val  in  3  threshold value.
REQ-012 irq_valid  out  1; irq_id  out  ID_WIDTH; irq_ready  in  1  claimed-ID handoff to core.
REQ-013 irq_done  in  1  one-cycle pulse: core handler finished.
REQ-014 busy  out  1  state != IDLE; err  out  1  sticky error; spurious_cnt  out  16  spurious-claim count.

Function
REQ-015 Addresses: CTX = BASE_ADDR + 0x200000 + CONTEXT_ID*0x20; threshold at CTX+0x0, claim/complete at CTX+0x4.
REQ-016 States: IDLE, THRESH, CLAIM, DISPATCH, SERVICE, COMPLETE.
REQ-017 IDLE: pending threshold request -> THRESH; else ext_irq=1 -> CLAIM; else stay; threshold has priority when both present.
REQ-018 thr_wr in any state SHALL latch thr_val into a one-deep pending slot (later pulse overwrites) serviced on next IDLE.
REQ-019 THRESH: mmio_write=1, addr CTX+0x0, data zero-extended thr_val, byte_en 8'h0F, held until mmio_ready=1; then clear pending slot, -> IDLE.
REQ-020 CLAIM: mmio_read=1, addr CTX+0x4, byte_en 8'h0F, held until mmio_ready=1; capture mmio_read_data[ID_WIDTH-1:0] that cycle.
REQ-021 CLAIM response ID 0 (spurious): spurious_cnt += 1 saturating at 16'hFFFF, -> IDLE, no complete write.
REQ-022 CLAIM response nonzero: -> DISPATCH with irq_id = captured ID.
REQ-023 DISPATCH: irq_valid=1, irq_id stable; on irq_valid & irq_ready -> SERVICE; irq_valid low in all other states.
REQ-024 SERVICE: wait for irq_done=1 -> COMPLETE; ext_irq ignored; irq_done outside SERVICE ignored.
REQ-025 COMPLETE: mmio_write=1, addr CTX+0x4, data zero-extended captured ID, byte_en 8'h0F, held until mmio_ready=1; -> IDLE.
REQ-026 Request outputs (addr, data, strobes, byte_en) SHALL be registered, stable while strobe high; idle values all zero.
REQ-027 Minimum latency: ext_irq high in IDLE at edge N -> mmio_read high after edge N; full claim-to-complete with zero-wait responder and immediate core = 5 cycles.
REQ-028 mmio_error=1 with mmio_ready=1 in THRESH/CLAIM/COMPLETE: set err, drop strobe, -> IDLE; CLAIM error yields no dispatch.
REQ-029 Timeout: counter counts cycles a strobe is held without mmio_ready; reaching TIMEOUT_CYCLES sets err, drops strobe, -> IDLE; counter clears on every state entry.
REQ-030 err SHALL be cleared only by rst.
REQ-031 After COMPLETE the FSM SHALL spend at least one cycle in IDLE before a new CLAIM.

Reset
REQ-032 rst=1 at any edge, including mid-transaction: state IDLE, all strobes 0, mmio_addr/data/byte_en 0, irq_valid 0, irq_id 0, busy 0, err 0, spurious_cnt 0, pending threshold slot empty, timeout counter 0.
REQ-033 Reset mid-transaction SHALL abandon it with no completing write.

Verification
REQ-034 CONTEXT_ID=1, ext_irq=1, responder returns 0x7 at zero wait, irq_ready=1, irq_done after 3 cycles -> read at 0x0C200024, irq_id=7, write 0x7 to 0x0C200024, busy low afterwards.
REQ-035 Claim returns 0 three times -> spurious_cnt=3, no mmio_write, irq_valid never high.
REQ-036 thr_wr with thr_val=5 and ext_irq simultaneous in IDLE -> write 0x5 to CTX+0x0 first, then claim read.
REQ-037 mmio_ready held low in CLAIM, TIMEOUT_CYCLES=16 -> strobe drops after 16 cycles, err=1, FSM IDLE.
REQ-038 rst asserted in SERVICE with ID 0x1F -> all outputs reset values next cycle, no complete write to CTX+0x4.
REQ-039 mmio_error on complete write -> err=1, IDLE; next ext_irq still serviced normally with err remaining 1.
